// File: rtl/ddr_channel_arb_n_if.sv
`default_nettype none
// ============================================================================
// ddr_channel_arb_n_if : client-side and DDR-side bundle of the N-channel arbiter
// Rev 1.0
// ============================================================================
interface ddr_channel_arb_n_if #(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = 19
);
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH-1:0]       req_ready;
  logic [NUM_CH*IDX_W-1:0] req_index;
  logic [NUM_CH-1:0]       req_write;
  logic [NUM_CH-1:0]       req_burst;
  logic [NUM_CH*64-1:0]    req_wmask;
  logic [NUM_CH*64-1:0]    req_wdata;
  logic [NUM_CH-1:0]       flush;
  logic [NUM_CH-1:0]       resp_done;
  logic [63:0]             resp_rdata;
  logic [511:0]            resp_burst_data;

  logic                    ddr_chip_enable;
  logic [IDX_W-1:0]        ddr_index;
  logic                    ddr_write_enable;
  logic                    ddr_burst_mode;
  logic [63:0]             ddr_opstore_write_mask;
  logic [63:0]             ddr_opstore_write_data;
  logic [63:0]             ddr_opload_read_data;
  logic [511:0]            ddr_pc_read_inst;
  logic                    ddr_operation_done;
  logic                    ddr_ready;

  modport slave (
    input  req_valid, req_index, req_write, req_burst, req_wmask, req_wdata, flush,
    input  ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready,
    output req_ready, resp_done, resp_rdata, resp_burst_data,
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    output ddr_opstore_write_mask, ddr_opstore_write_data
  );

  modport master (
    output req_valid, req_index, req_write, req_burst, req_wmask, req_wdata, flush,
    output ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready,
    input  req_ready, resp_done, resp_rdata, resp_burst_data,
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    input  ddr_opstore_write_mask, ddr_opstore_write_data
  );
endinterface
`default_nettype wire

// File: rtl/ddr_channel_arb_n.sv
`default_nettype none
// ============================================================================
// ddr_channel_arb_n : N-channel round-robin / fixed-priority DDR port arbiter
// Rev 1.0
// ============================================================================
module ddr_channel_arb_n #(
  parameter int NUM_CH   = 3,
  parameter int IDX_W    = 19,
  parameter int ARB_MODE = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  ddr_channel_arb_n_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, gnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q, burst_q, cancel_q;
  logic [63:0]       wm_q, wd_q, rdata_q;
  logic [511:0]      bdata_q;
  logic [NUM_CH-1:0] resp_done_q;

  logic [NUM_CH-1:0] elig;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx, rr_next;
  logic [CH_W:0]     k;
  logic              flush_g, cancel_now, busy, op_done;

  logic [IDX_W-1:0]  idx_a [NUM_CH];
  logic [63:0]       wm_a  [NUM_CH];
  logic [63:0]       wd_a  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign idx_a[c] = bus.req_index[c*IDX_W +: IDX_W];
    assign wm_a[c]  = bus.req_wmask[c*64 +: 64];
    assign wd_a[c]  = bus.req_wdata[c*64 +: 64];
  end

  // Scan starts at rr_ptr (round-robin) or channel 0 (fixed priority); first eligible wins.
  always_comb begin
    elig      = bus.req_valid & ~bus.flush;
    grant_vld = 1'b0;
    grant_idx = '0;
    k         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 1) begin
        k = (CH_W+1)'(i);
      end else begin
        k = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
        if (k >= (CH_W+1)'(NUM_CH)) k = k - (CH_W+1)'(NUM_CH);
      end
      if (!grant_vld && elig[k[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = k[CH_W-1:0];
      end
    end
    if (state_q != S_IDLE || !bus.ddr_ready) grant_vld = 1'b0;
  end

  assign rr_next    = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
  assign flush_g    = bus.flush[gnt_q];
  assign cancel_now = cancel_q | flush_g;
  assign op_done    = (state_q == S_WAIT) && bus.ddr_operation_done;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.ddr_operation_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      burst_q     <= 1'b0;
      wm_q        <= '0;
      wd_q        <= '0;
      cancel_q    <= 1'b0;
      resp_done_q <= '0;
      rdata_q     <= '0;
      bdata_q     <= '0;
    end else begin
      resp_done_q <= '0;
      if (grant_vld) begin
        gnt_q   <= grant_idx;
        idx_q   <= idx_a[grant_idx];
        wr_q    <= bus.req_write[grant_idx];
        burst_q <= bus.req_burst[grant_idx];
        wm_q    <= wm_a[grant_idx];
        wd_q    <= wd_a[grant_idx];
        if (ARB_MODE == 0) rr_ptr_q <= rr_next;
      end
      if (op_done) begin
        rdata_q <= bus.ddr_opload_read_data;
        bdata_q <= bus.ddr_pc_read_inst;
        if (!cancel_now) resp_done_q <= {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_q;
      end
      // A flush landing on the completion cycle itself is covered by cancel_now above.
      if (!busy || op_done) cancel_q <= 1'b0;
      else if (flush_g)     cancel_q <= 1'b1;
    end
  end

  assign bus.req_ready              = grant_vld ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign bus.resp_done              = resp_done_q;
  assign bus.resp_rdata             = rdata_q;
  assign bus.resp_burst_data        = bdata_q;
  assign bus.ddr_chip_enable        = (state_q == S_ISSUE);
  assign bus.ddr_index              = busy ? idx_q   : '0;
  assign bus.ddr_write_enable       = busy ? wr_q    : 1'b0;
  assign bus.ddr_burst_mode         = busy ? burst_q : 1'b0;
  assign bus.ddr_opstore_write_mask = busy ? wm_q    : '0;
  assign bus.ddr_opstore_write_data = busy ? wd_q    : '0;
endmodule
`default_nettype wire

// File: tb/tb_ddr_channel_arb_n.sv
`default_nettype none
// ============================================================================
// tb_ddr_channel_arb_n : directed bench for round-robin and fixed-priority arbiters
// Rev 1.0
// ============================================================================
module tb_ddr_channel_arb_n;
  logic clock;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   ce_cnt   = 0;
  int   ce_base;

  logic [18:0]  e_idx [3];
  logic         e_wr  [3];
  logic         e_bu  [3];
  logic [63:0]  e_wm  [3];
  logic [63:0]  e_wd  [3];
  logic [511:0] bpat;

  ddr_channel_arb_n_if #(.NUM_CH(3), .IDX_W(19)) rb ();
  ddr_channel_arb_n_if #(.NUM_CH(3), .IDX_W(19)) fb ();

  ddr_channel_arb_n #(.NUM_CH(3), .IDX_W(19), .ARB_MODE(0)) u_rr (
    .clock(clock), .reset_n(reset_n), .bus(rb));
  ddr_channel_arb_n #(.NUM_CH(3), .IDX_W(19), .ARB_MODE(1)) u_fp (
    .clock(clock), .reset_n(reset_n), .bus(fb));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (rb.ddr_chip_enable === 1'b1) ce_cnt <= ce_cnt + 1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_ch(input int c, input logic [18:0] idx, input logic wr, input logic bu,
                        input logic [63:0] wm, input logic [63:0] wd);
    e_idx[c] = idx; e_wr[c] = wr; e_bu[c] = bu; e_wm[c] = wm; e_wd[c] = wd;
    rb.req_index[c*19 +: 19] = idx;
    rb.req_write[c]          = wr;
    rb.req_burst[c]          = bu;
    rb.req_wmask[c*64 +: 64] = wm;
    rb.req_wdata[c*64 +: 64] = wd;
  endtask

  // Entered in an IDLE cycle with requests applied; returns in the IDLE cycle after completion.
  task automatic rb_op(input string tag, input int g, input int extra_wait, input logic [2:0] vld_after,
                       input bit fl_wait, input bit fl_done, input logic [63:0] rd);
    logic [2:0] oh;
    oh = 3'b001 << g;
    #1 chk({tag, ".ready"}, rb.req_ready, oh);
    tick();
    chk({tag, ".ce"},  rb.ddr_chip_enable,  1'b1);
    chk({tag, ".idx"}, rb.ddr_index,        e_idx[g]);
    chk({tag, ".we"},  rb.ddr_write_enable, e_wr[g]);
    chk({tag, ".bm"},  rb.ddr_burst_mode,   e_bu[g]);
    if (e_wr[g]) begin
      chk({tag, ".wm"}, rb.ddr_opstore_write_mask, e_wm[g]);
      chk({tag, ".wd"}, rb.ddr_opstore_write_data, e_wd[g]);
    end
    tick();
    for (int i = 0; i < extra_wait; i++) begin
      rb.flush[g] = fl_wait;
      tick();
      rb.flush[g] = 1'b0;
    end
    chk({tag, ".hold"}, {rb.ddr_chip_enable, rb.ddr_index}, {1'b0, e_idx[g]});
    rb.ddr_operation_done   = 1'b1;
    rb.ddr_opload_read_data = rd;
    rb.flush[g]             = fl_done;
    rb.req_valid            = vld_after;
    tick();
    rb.ddr_operation_done   = 1'b0;
    rb.ddr_opload_read_data = '0;
    rb.flush[g]             = 1'b0;
    chk({tag, ".done"}, rb.resp_done, (fl_wait || fl_done) ? 3'b000 : oh);
    if (!(fl_wait || fl_done)) chk({tag, ".rdata"}, rb.resp_rdata, rd);
  endtask

  initial begin
    reset_n = 1'b0;
    rb.req_valid = '0; rb.req_index = '0; rb.req_write = '0; rb.req_burst = '0;
    rb.req_wmask = '0; rb.req_wdata = '0; rb.flush = '0;
    rb.ddr_opload_read_data = '0; rb.ddr_pc_read_inst = '0;
    rb.ddr_operation_done = 1'b0; rb.ddr_ready = 1'b0;
    fb.req_valid = '0; fb.req_index = '0; fb.req_write = '0; fb.req_burst = '0;
    fb.req_wmask = '0; fb.req_wdata = '0; fb.flush = '0;
    fb.ddr_opload_read_data = '0; fb.ddr_pc_read_inst = '0;
    fb.ddr_operation_done = 1'b0; fb.ddr_ready = 1'b0;
    bpat = {16{32'hA5A5_0F0F}};

    repeat (3) @(posedge clock);
    #3;
    chk("rst.ready", rb.req_ready, 3'b000);
    chk("rst.done",  rb.resp_done, 3'b000);
    chk("rst.ce",    rb.ddr_chip_enable, 1'b0);
    chk("rst.idx",   rb.ddr_index, 19'h0);
    chk("rst.rdata", rb.resp_rdata, 64'h0);
    @(negedge clock) reset_n = 1'b1;
    tick();

    // Fixed priority: channel 1 keeps winning until it stops requesting.
    fb.ddr_ready = 1'b0; fb.req_valid = 3'b110;
    #1 chk("fp.notready", fb.req_ready, 3'b000);
    tick();
    fb.ddr_ready = 1'b1;
    #1 chk("fp.g1a", fb.req_ready, 3'b010);
    tick(); tick();
    fb.ddr_operation_done = 1'b1;
    tick();
    fb.ddr_operation_done = 1'b0;
    #1 chk("fp.done1a", fb.resp_done, 3'b010);
    chk("fp.g1b", fb.req_ready, 3'b010);
    tick(); tick();
    fb.ddr_operation_done = 1'b1; fb.req_valid = 3'b100;
    tick();
    fb.ddr_operation_done = 1'b0;
    #1 chk("fp.done1b", fb.resp_done, 3'b010);
    chk("fp.g2", fb.req_ready, 3'b100);
    tick(); tick();
    fb.ddr_operation_done = 1'b1; fb.req_valid = 3'b000;
    tick();
    fb.ddr_operation_done = 1'b0;
    #1 chk("fp.done2", fb.resp_done, 3'b100);
    tick();

    // Round-robin with all channels requesting, done two cycles after issue.
    for (int c = 0; c < 3; c++) set_ch(c, 19'h100 + 19'(c), 1'b0, 1'b0, 64'h0, 64'h0);
    rb.ddr_ready = 1'b1;
    ce_base = ce_cnt;
    rb.req_valid = 3'b111;
    rb_op("rr0", 0, 1, 3'b111, 1'b0, 1'b0, 64'hA0);
    rb_op("rr1", 1, 1, 3'b111, 1'b0, 1'b0, 64'hA1);
    rb_op("rr2", 2, 1, 3'b111, 1'b0, 1'b0, 64'hA2);
    rb_op("rr3", 0, 1, 3'b000, 1'b0, 1'b0, 64'hA3);
    #1 chk("rr.idle_ready", rb.req_ready, 3'b000);
    chk("rr.ce_count", ce_cnt - ce_base, 4);
    tick();

    // Minimum-latency read with load and burst data capture.
    set_ch(0, 19'h1234, 1'b0, 1'b0, 64'h0, 64'h0);
    rb.ddr_pc_read_inst = bpat;
    rb.req_valid = 3'b001;
    rb_op("rd", 0, 0, 3'b000, 1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D);
    chk("rd.burst", rb.resp_burst_data, bpat);
    rb.ddr_pc_read_inst = '0;
    tick();
    chk("rd.pulse1", rb.resp_done, 3'b000);
    chk("rd.hold",   rb.resp_rdata, 64'hDEADBEEF_CAFEF00D);
    chk("rd.bhold",  rb.resp_burst_data, bpat);

    // Burst write on channel 2 flushed in WAIT, then normal and done-cycle-flushed channel 1 ops.
    set_ch(2, 19'h7_0002, 1'b1, 1'b1, 64'hFF, 64'h55);
    rb.req_valid = 3'b100;
    rb_op("bw", 2, 1, 3'b000, 1'b1, 1'b0, 64'h0);
    set_ch(1, 19'h0_0ABC, 1'b0, 1'b0, 64'h0, 64'h0);
    rb.req_valid = 3'b010;
    rb_op("nx", 1, 1, 3'b000, 1'b0, 1'b0, 64'h5151);
    rb.req_valid = 3'b010;
    rb_op("fd", 1, 1, 3'b000, 1'b0, 1'b1, 64'h77);

    // Flush masks an IDLE request; then reset lands mid-operation.
    rb.req_valid = 3'b001; rb.flush = 3'b001;
    #1 chk("fl.blocked", rb.req_ready, 3'b000);
    tick();
    chk("fl.noissue", rb.ddr_chip_enable, 1'b0);
    rb.flush = 3'b000;
    #1 chk("fl.release", rb.req_ready, 3'b001);
    tick();
    rb.req_valid = 3'b000;
    chk("rst2.issue", rb.ddr_chip_enable, 1'b1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst2.ce",    rb.ddr_chip_enable, 1'b0);
    chk("rst2.idx",   rb.ddr_index, 19'h0);
    chk("rst2.we",    rb.ddr_write_enable, 1'b0);
    chk("rst2.rdata", rb.resp_rdata, 64'h0);
    chk("rst2.done",  rb.resp_done, 3'b000);
    @(negedge clock) reset_n = 1'b1;
    tick();
    rb.ddr_operation_done = 1'b1;
    tick();
    rb.ddr_operation_done = 1'b0;
    #1 chk("stray.done", rb.resp_done, 3'b000);
    chk("stray.ce", rb.ddr_chip_enable, 1'b0);
    tick();
    chk("stray.ce2",  rb.ddr_chip_enable, 1'b0);
    chk("stray.done2", rb.resp_done, 3'b000);

    // First request after reset must start from pointer 0.
    for (int c = 0; c < 3; c++) set_ch(c, 19'h40 + 19'(c), 1'b0, 1'b0, 64'h0, 64'h0);
    rb.req_valid = 3'b111;
    rb_op("post", 0, 0, 3'b000, 1'b0, 1'b0, 64'h99);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
